// File: rtl/jump_pkg.sv
// Shared constants and decode helper for the jump-resolution unit and its return-address stack.
package jump_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [4:0] RA_IDX   = 5'd31;

  typedef enum logic [2:0] {
    JK_NONE,
    JK_J,
    JK_JAL,
    JK_JR,
    JK_JALR
  } jump_kind_e;

  // Stack pointer width; a one-bit floor keeps degenerate depths legal.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic jump_kind_e decode_jump(input logic vld, input logic [5:0] op,
                                             input logic [5:0] fn);
    if (!vld)                          return JK_NONE;
    if (op == OP_J)                    return JK_J;
    if (op == OP_JAL)                  return JK_JAL;
    if (op == OP_RTYPE && fn == FN_JR)   return JK_JR;
    if (op == OP_RTYPE && fn == FN_JALR) return JK_JALR;
    return JK_NONE;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// simultaneous pop+push replaces the top in place.
module ras_stack
  import jump_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic             empty,
  output logic             full
);

  localparam int PW = ptr_w(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_m1;
  logic [CW-1:0]    count;

  // top points at the next free slot; the live top entry sits one below it.
  assign top_m1    = top - PW'(1);
  assign empty     = (count == '0);
  assign full      = (count == CW'(RAS_DEPTH));
  assign pop_valid = pop && !empty;
  assign pop_data  = mem[top_m1];

  always_ff @(posedge clock) begin
    if (reset) begin
      top   <= '0;
      count <= '0;
    end else if (pop_valid && push) begin
      top   <= top;
      count <= count;
    end else if (pop_valid) begin
      top   <= top_m1;
      count <= count - CW'(1);
    end else if (push) begin
      top   <= top + PW'(1);
      if (!full) count <= count + CW'(1);
    end
  end

  // Contents need no reset; occupancy alone defines what is live.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (pop_valid && push) mem[top_m1] <= push_data;
      else if (push && !pop_valid) mem[top] <= push_data;
    end
  end

endmodule

// File: rtl/jump_unit.sv
// Resolves J/JAL/JR/JALR into a registered redirect and link write.
// Define JUMP_UNIT_RAS_EN to build in the return-address stack predictor.
module jump_unit
  import jump_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic [4:0]       rs_idx,
  input  logic [25:0]      instr_index,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] pc_plus4,
  output logic             jump_taken,
  output logic [WIDTH-1:0] jump_target,
  output logic             link_write,
  output logic [WIDTH-1:0] link_addr,
  output logic             ras_valid,
  output logic [WIDTH-1:0] ras_predict,
  output logic             ras_mispredict,
  output logic             ras_empty,
  output logic             ras_full
);

  jump_kind_e       kind;
  logic             is_abs, is_reg, taken, link, ret, push;
  logic [WIDTH-1:0] abs_tgt, tgt;

  assign kind   = decode_jump(valid, opcode, func);
  assign is_abs = (kind == JK_J)  || (kind == JK_JAL);
  assign is_reg = (kind == JK_JR) || (kind == JK_JALR);
  assign taken  = is_abs || is_reg;
  assign link   = (kind == JK_JAL) || (kind == JK_JALR);
  assign ret    = is_reg && (rs_idx == RA_IDX);
  // Every linking jump pushes; JALR $ra also pops, which the stack turns into a top replace.
  assign push   = link;

  if (WIDTH > 28) begin : g_region
    assign abs_tgt = {pc_plus4[WIDTH-1:28], instr_index, 2'b00};
  end else begin : g_noregion
    assign abs_tgt = {instr_index, 2'b00};
  end

  assign tgt = is_abs ? abs_tgt : rs_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      jump_taken  <= 1'b0;
      jump_target <= '0;
      link_write  <= 1'b0;
      link_addr   <= '0;
    end else begin
      jump_taken  <= taken;
      jump_target <= taken ? tgt : '0;
      link_write  <= link;
      link_addr   <= link ? pc_plus4 : '0;
    end
  end

`ifdef JUMP_UNIT_RAS_EN
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;

  ras_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (ret),
    .push_data (pc_plus4),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ras_valid      <= 1'b0;
      ras_predict    <= '0;
      ras_mispredict <= 1'b0;
    end else begin
      ras_valid      <= pop_valid;
      ras_predict    <= pop_valid ? pop_data : '0;
      ras_mispredict <= pop_valid && (pop_data != rs_data);
    end
  end
`else
  logic unused_ras;
  assign unused_ras     = ^{ret, push};
  assign ras_valid      = 1'b0;
  assign ras_predict    = '0;
  assign ras_mispredict = 1'b0;
  assign ras_empty      = 1'b1;
  assign ras_full       = 1'b0;
`endif

endmodule
